// File: rtl/mio_bus_hs.sv
// Handshaked MIO decoder: takes one CPU access at a time and steers it to the data RAM
// (fixed read latency) or to a peripheral channel (req/ack with timeout).

// One peripheral channel: select, gated ack and gated read data for channel CH.
module mio_ch_slice #(
  parameter int CH = 0
) (
  input  logic        active_i,
  input  logic [2:0]  ch_i,
  input  logic        ack_i,
  input  logic [31:0] rdata_i,
  output logic        sel_o,
  output logic        ack_o,
  output logic [31:0] rdata_o
);
  logic hit;

  assign hit     = active_i && (ch_i == 3'(CH));
  assign sel_o   = hit;
  assign ack_o   = hit && ack_i;
  assign rdata_o = hit ? rdata_i : 32'd0;
endmodule

module mio_bus_hs #(
  parameter int          RAM_AW     = 10,
  parameter int          RAM_RD_LAT = 1,
  parameter int          NUM_CH     = 4,
  parameter int          TIMEOUT    = 15,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_err,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic [NUM_CH-1:0]     periph_sel,
  output logic                  periph_we,
  output logic [31:0]           periph_wdata,
  input  logic [NUM_CH*32-1:0]  periph_rdata,
  input  logic [NUM_CH-1:0]     periph_ack
);
  typedef enum logic [1:0] {IDLE, RAM_RD, PER_WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic [7:0] LAT_C = 8'(RAM_RD_LAT);
  localparam logic [7:0] TO_C  = 8'(TIMEOUT);

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        ramwr_q, ramwr_d;

  logic                    per_active;
  logic [NUM_CH-1:0]       sel_vec, ack_vec;
  logic [NUM_CH-1:0][31:0] rd_vec;
  logic [31:0]             ack_rdata;
  logic                    ack_hit;
  logic                    ch_ok;
  logic                    unused_addr;

  assign per_active = (state_q == PER_WAIT);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mio_ch_slice #(.CH(c)) u_ch (
      .active_i (per_active),
      .ch_i     (req_q.addr[4:2]),
      .ack_i    (periph_ack[c]),
      .rdata_i  (periph_rdata[c*32 +: 32]),
      .sel_o    (sel_vec[c]),
      .ack_o    (ack_vec[c]),
      .rdata_o  (rd_vec[c])
    );
  end

  // Slices zero their data when not selected, so an OR acts as the channel mux.
  always_comb begin
    ack_rdata = '0;
    for (int c = 0; c < NUM_CH; c++) ack_rdata |= rd_vec[c];
  end

  assign ack_hit = |ack_vec;
  assign ch_ok   = ({29'd0, cpu_addr[4:2]} < 32'(NUM_CH));

  // Only the region, channel and word-address fields are decoded; the rest is don't-care.
  assign unused_addr = ^req_q.addr;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ramwr_d    = ramwr_q;
    cpu_ready  = 1'b0;
    cpu_err    = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    periph_sel = '0;
    periph_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          req_d   = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
          cnt_d   = 8'd1;
          err_d   = 1'b0;
          ramwr_d = 1'b0;
          if (cpu_addr[31:28] == 4'h0) begin
            if (cpu_we) begin
              ramwr_d = 1'b1;
              state_d = RESP;
            end else begin
              state_d = RAM_RD;
            end
          end else if (cpu_addr[31:28] == 4'hF && ch_ok) begin
            state_d = PER_WAIT;
          end else begin
            err_d   = 1'b1;
            rdata_d = ERR_DATA;
            state_d = RESP;
          end
        end
      end
      RAM_RD: begin
        ram_en = (cnt_q == 8'd1);
        if (cnt_q == LAT_C) begin
          rdata_d = ram_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PER_WAIT: begin
        periph_sel = sel_vec;
        periph_we  = req_q.we;
        // An ack in the last allowed cycle still counts as success.
        if (ack_hit) begin
          if (!req_q.we) rdata_d = ack_rdata;
          state_d = RESP;
        end else if (cnt_q >= TO_C) begin
          err_d   = 1'b1;
          rdata_d = ERR_DATA;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        cpu_ready = 1'b1;
        cpu_err   = err_q;
        ram_en    = ramwr_q;
        ram_we    = ramwr_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ramwr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ramwr_q <= ramwr_d;
    end
  end

  assign cpu_rdata    = rdata_q;
  assign ram_addr     = req_q.addr[RAM_AW+1:2];
  assign ram_wdata    = req_q.wdata;
  assign periph_wdata = req_q.wdata;
endmodule

// File: tb/tb_mio_bus_hs.sv
// Self-checking bench for mio_bus_hs: expected responses are queued per access and
// compared when cpu_ready is observed.
module tb_mio_bus_hs;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready, cpu_err;
  logic         ram_en, ram_we;
  logic [9:0]   ram_addr;
  logic [31:0]  ram_wdata;
  logic [31:0]  ram_rdata = '0;
  logic [3:0]   periph_sel;
  logic         periph_we;
  logic [31:0]  periph_wdata;
  logic [127:0] periph_rdata;
  logic [3:0]   periph_ack = '0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
    logic        chk_rd;
  } exp_t;
  exp_t sb[$];

  logic [3:0] sel_h [0:63];
  logic       en_h  [0:63];
  logic       we_h  [0:63];
  logic       pwe_h [0:63];
  logic [9:0] addr_h[0:63];
  logic [31:0] mem  [0:1023];

  always #5 clk = ~clk;

  mio_bus_hs #(.RAM_AW(10), .RAM_RD_LAT(2), .NUM_CH(4), .TIMEOUT(15),
               .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .periph_sel(periph_sel), .periph_we(periph_we),
    .periph_wdata(periph_wdata), .periph_rdata(periph_rdata), .periph_ack(periph_ack)
  );

  // Synchronous RAM: read data appears the cycle after ram_en.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // Drives one access; records strobes per cycle and the cycle index of cpu_ready (-1 on expiry).
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input int maxc, input int ack_cyc, input int ack_ch,
                            input int bad_cyc, input int bad_ch,
                            output int rcyc, output logic [31:0] rd, output logic er);
    rcyc = -1; rd = '0; er = 1'b0;
    for (int i = 0; i < 64; i++) begin
      sel_h[i] = '0; en_h[i] = 1'b0; we_h[i] = 1'b0; pwe_h[i] = 1'b0; addr_h[i] = '0;
    end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; periph_ack = '0;
    for (int k = 1; k <= maxc && rcyc < 0; k++) begin
      @(negedge clk);
      sel_h[k] = periph_sel; en_h[k] = ram_en; we_h[k] = ram_we;
      pwe_h[k] = periph_we; addr_h[k] = ram_addr;
      if (cpu_ready) begin
        rcyc = k; rd = cpu_rdata; er = cpu_err; cpu_req = 1'b0;
      end
      periph_ack = '0;
      if (k == ack_cyc) periph_ack = 4'(1 << ack_ch);
      if (k == bad_cyc) periph_ack = 4'(1 << bad_ch);
    end
    periph_ack = '0;
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({cpu_ready, cpu_err, ram_en, ram_we, periph_sel, periph_we} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b want 0",
               {cpu_ready, cpu_err, ram_en, ram_we, periph_sel, periph_we});
    end
    n_cmp++;
    if (cpu_rdata !== 32'd0) begin
      n_err++; $display("FAIL reset_rdata: got %h want 0", cpu_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ram();
    int rc; logic [31:0] rd; logic er; exp_t e;
    sb.push_back('{32'h0, 1'b0, 1, 1'b0});
    run_access(1'b1, 32'h0000_0010, 32'h1234_5678, 10, -1, 0, -1, 0, rc, rd, er);
    e = sb.pop_front();
    n_cmp++;
    if (rc !== e.cyc || er !== e.err) begin
      n_err++; $display("FAIL ram_wr_resp: got cyc %0d err %b want cyc %0d err %b", rc, er, e.cyc, e.err);
    end
    n_cmp++;
    if ({en_h[1], we_h[1], addr_h[1]} !== {1'b1, 1'b1, 10'd4}) begin
      n_err++; $display("FAIL ram_wr_strobe: got en %b we %b addr %0d want 1 1 4", en_h[1], we_h[1], addr_h[1]);
    end
    sb.push_back('{32'h1234_5678, 1'b0, 3, 1'b1});
    run_access(1'b0, 32'h0000_0010, 32'h0, 10, -1, 0, -1, 0, rc, rd, er);
    e = sb.pop_front();
    n_cmp++;
    if (rc !== e.cyc || er !== e.err || rd !== e.rd) begin
      n_err++; $display("FAIL ram_rd_resp: got cyc %0d err %b rd %h want cyc %0d err %b rd %h", rc, er, rd, e.cyc, e.err, e.rd);
    end
    n_cmp++;
    if ({en_h[1], we_h[1], en_h[2]} !== 3'b100) begin
      n_err++; $display("FAIL ram_rd_en: got %b want 100", {en_h[1], we_h[1], en_h[2]});
    end
  endtask

  task automatic test_periph_read();
    int rc; logic [31:0] rd; logic er; exp_t e;
    sb.push_back('{32'hA5A5_0001, 1'b0, 4, 1'b1});
    run_access(1'b0, 32'hF000_0008, 32'h0, 20, 3, 2, -1, 0, rc, rd, er);
    e = sb.pop_front();
    n_cmp++;
    if (rc !== e.cyc || er !== e.err || rd !== e.rd) begin
      n_err++; $display("FAIL per_rd_resp: got cyc %0d err %b rd %h want cyc %0d err %b rd %h", rc, er, rd, e.cyc, e.err, e.rd);
    end
    n_cmp++;
    if ({sel_h[1], sel_h[2], sel_h[3], sel_h[4]} !== 16'b0100_0100_0100_0000) begin
      n_err++; $display("FAIL per_rd_sel: got %b %b %b %b want 0100 0100 0100 0000", sel_h[1], sel_h[2], sel_h[3], sel_h[4]);
    end
  endtask

  task automatic test_timeout();
    int rc; logic [31:0] rd; logic er; exp_t e; logic bad;
    sb.push_back('{32'hDEAD_BEEF, 1'b1, 16, 1'b1});
    run_access(1'b1, 32'hF000_0004, 32'h0BAD_F00D, 30, -1, 0, -1, 0, rc, rd, er);
    e = sb.pop_front();
    n_cmp++;
    if (rc !== e.cyc || er !== e.err || rd !== e.rd) begin
      n_err++; $display("FAIL timeout_resp: got cyc %0d err %b rd %h want cyc %0d err %b rd %h", rc, er, rd, e.cyc, e.err, e.rd);
    end
    n_cmp++;
    if ({sel_h[1], sel_h[15], sel_h[16], pwe_h[1]} !== 13'b0010_0010_0000_1) begin
      n_err++; $display("FAIL timeout_sel: got %b %b %b we %b want 0010 0010 0000 1", sel_h[1], sel_h[15], sel_h[16], pwe_h[1]);
    end
    bad = 1'b0;
    for (int k = 17; k <= 24; k++) begin
      @(negedge clk);
      bad |= cpu_ready | (|periph_sel);
      periph_ack = (k == 20) ? 4'b0010 : 4'b0000;
    end
    periph_ack = '0;
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++; $display("FAIL late_ack: got activity %b want 0", bad);
    end
  endtask

  task automatic test_unmapped();
    int rc; logic [31:0] rd; logic er; exp_t e;
    logic [31:0] addrs [2];
    addrs[0] = 32'h5000_0000; addrs[1] = 32'hF000_0018;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{32'hDEAD_BEEF, 1'b1, 1, 1'b1});
      run_access(1'b0, addrs[i], 32'h0, 10, -1, 0, -1, 0, rc, rd, er);
      e = sb.pop_front();
      n_cmp++;
      if (rc !== e.cyc || er !== e.err || rd !== e.rd) begin
        n_err++; $display("FAIL unmapped_resp %h: got cyc %0d err %b rd %h want cyc %0d err %b rd %h", addrs[i], rc, er, rd, e.cyc, e.err, e.rd);
      end
      n_cmp++;
      if ({en_h[1], sel_h[1]} !== 5'd0) begin
        n_err++; $display("FAIL unmapped_strobe %h: got en %b sel %b want 0 0000", addrs[i], en_h[1], sel_h[1]);
      end
    end
  endtask

  task automatic test_ack_at_timeout();
    int rc; logic [31:0] rd; logic er; exp_t e;
    sb.push_back('{32'h3333_CAFE, 1'b0, 16, 1'b1});
    run_access(1'b0, 32'hF000_000C, 32'h0, 30, 15, 3, -1, 0, rc, rd, er);
    e = sb.pop_front();
    n_cmp++;
    if (rc !== e.cyc || er !== e.err || rd !== e.rd) begin
      n_err++; $display("FAIL ack_at_timeout: got cyc %0d err %b rd %h want cyc %0d err %b rd %h", rc, er, rd, e.cyc, e.err, e.rd);
    end
  endtask

  task automatic test_wrong_channel();
    int rc; logic [31:0] rd; logic er; exp_t e;
    sb.push_back('{32'h1111_BEEF, 1'b0, 6, 1'b1});
    run_access(1'b0, 32'hF000_0004, 32'h0, 30, 5, 1, 2, 0, rc, rd, er);
    e = sb.pop_front();
    n_cmp++;
    if (rc !== e.cyc || er !== e.err || rd !== e.rd) begin
      n_err++; $display("FAIL wrong_ch_resp: got cyc %0d err %b rd %h want cyc %0d err %b rd %h", rc, er, rd, e.cyc, e.err, e.rd);
    end
    n_cmp++;
    if (sel_h[3] !== 4'b0010) begin
      n_err++; $display("FAIL wrong_ch_sel: got %b want 0010", sel_h[3]);
    end
  endtask

  task automatic test_back_to_back();
    int rc; logic [31:0] rd; logic er; exp_t e;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'hAAAA_0020;
    @(negedge clk);
    n_cmp++;
    if ({cpu_ready, ram_we, ram_addr} !== {1'b1, 1'b1, 10'd8}) begin
      n_err++; $display("FAIL b2b_first: got rdy %b we %b addr %0d want 1 1 8", cpu_ready, ram_we, ram_addr);
    end
    cpu_addr = 32'h0000_0024; cpu_wdata = 32'hBBBB_0024;
    @(negedge clk);
    n_cmp++;
    if (cpu_ready !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: got rdy %b want 0", cpu_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({cpu_ready, ram_we, ram_addr} !== {1'b1, 1'b1, 10'd9}) begin
      n_err++; $display("FAIL b2b_second: got rdy %b we %b addr %0d want 1 1 9", cpu_ready, ram_we, ram_addr);
    end
    cpu_req = 1'b0;
    sb.push_back('{32'hAAAA_0020, 1'b0, 3, 1'b1});
    run_access(1'b0, 32'h0000_0020, 32'h0, 10, -1, 0, -1, 0, rc, rd, er);
    e = sb.pop_front();
    n_cmp++;
    if (rc !== e.cyc || rd !== e.rd) begin
      n_err++; $display("FAIL b2b_readback: got cyc %0d rd %h want cyc %0d rd %h", rc, rd, e.cyc, e.rd);
    end
  endtask

  task automatic test_wrap();
    int rc; logic [31:0] rd; logic er; exp_t e;
    run_access(1'b1, 32'h0000_1010, 32'hC0FF_EE00, 10, -1, 0, -1, 0, rc, rd, er);
    n_cmp++;
    if (addr_h[1] !== 10'd4) begin
      n_err++; $display("FAIL wrap_addr: got %0d want 4", addr_h[1]);
    end
    sb.push_back('{32'hC0FF_EE00, 1'b0, 3, 1'b1});
    run_access(1'b0, 32'h0000_0013, 32'h0, 10, -1, 0, -1, 0, rc, rd, er);
    e = sb.pop_front();
    n_cmp++;
    if (rc !== e.cyc || er !== e.err || rd !== e.rd) begin
      n_err++; $display("FAIL wrap_read: got cyc %0d err %b rd %h want cyc %0d err %b rd %h", rc, er, rd, e.cyc, e.err, e.rd);
    end
  endtask

  task automatic test_reset_mid();
    int rc; logic [31:0] rd; logic er; exp_t e; logic bad;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hF000_0000;
    @(negedge clk);
    n_cmp++;
    if (periph_sel !== 4'b0001) begin
      n_err++; $display("FAIL rstmid_sel_before: got %b want 0001", periph_sel);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({periph_sel, cpu_ready, cpu_err} !== 6'd0) begin
      n_err++; $display("FAIL rstmid_drop: got sel %b rdy %b err %b want 0", periph_sel, cpu_ready, cpu_err);
    end
    cpu_req = 1'b0;
    bad = 1'b0;
    repeat (2) begin
      @(negedge clk);
      bad |= cpu_ready;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      bad |= cpu_ready;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++; $display("FAIL rstmid_noready: got %b want 0", bad);
    end
    sb.push_back('{32'hBBBB_0024, 1'b0, 3, 1'b1});
    run_access(1'b0, 32'h0000_0024, 32'h0, 10, -1, 0, -1, 0, rc, rd, er);
    e = sb.pop_front();
    n_cmp++;
    if (rc !== e.cyc || er !== e.err || rd !== e.rd) begin
      n_err++; $display("FAIL rstmid_fresh: got cyc %0d err %b rd %h want cyc %0d err %b rd %h", rc, er, rd, e.cyc, e.err, e.rd);
    end
  endtask

  initial begin
    periph_rdata = '0;
    periph_rdata[31:0]   = 32'h0000_AAAA;
    periph_rdata[63:32]  = 32'h1111_BEEF;
    periph_rdata[95:64]  = 32'hA5A5_0001;
    periph_rdata[127:96] = 32'h3333_CAFE;
    test_reset();
    test_ram();
    test_periph_read();
    test_timeout();
    test_unmapped();
    test_ack_at_timeout();
    test_wrong_channel();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
